// File: rtl/ctrl_pkg.sv
// Shared opcode/funct constants, ALUOp encodings and per-stage control bundle types
// for the pipelined MIPS control unit.
package ctrl_pkg;

    localparam logic [5:0] R_FORMAT = 6'h00;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] JAL      = 6'h03;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] ADDIU    = 6'h09;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2b;

    localparam logic [5:0] MULTU    = 6'h19;
    localparam logic [5:0] MFHI     = 6'h10;
    localparam logic [5:0] MFLO     = 6'h12;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
    } ctrl_bundle_t;

    // Narrower bundles: only the fields still consumed downstream are carried on.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic jal;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic jal;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode/funct decoder producing the control bundle,
// jump/branch flags, the rt-as-source flag and an undecodable flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output ctrl_bundle_t        ctrl,
    output logic                jump,
    output logic                branch,
    output logic                uses_rt,
    output logic                undecodable
);

    always_comb begin
        ctrl        = '0;
        jump        = 1'b0;
        branch      = 1'b0;
        uses_rt     = 1'b0;
        undecodable = 1'b0;
        case (opcode)
            OPCODE_W'(R_FORMAT): begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                // multu only writes HI/LO, never the register file
                ctrl.reg_write = (funct != FUNCT_W'(MULTU));
                uses_rt        = 1'b1;
            end
            OPCODE_W'(LW): begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OPCODE_W'(SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                uses_rt        = 1'b1;
            end
            OPCODE_W'(BEQ): begin
                branch      = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
                uses_rt     = 1'b1;
            end
            OPCODE_W'(ADDIU): begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OPCODE_W'(J): begin
                jump = 1'b1;
            end
            OPCODE_W'(JAL): begin
                jump           = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jal       = 1'b1;
            end
            default: begin
                undecodable = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control unit: ID decode, ID/EX/MEM/WB control registers, load-use stall
// and flush handling. Define CTRL_MUL_INTERLOCK_EN to add the multu HI/LO busy interlock.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2,
    parameter int LINK_REG = 31,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [FUNCT_W-1:0]  id_funct,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                id_jump,
    output logic                id_branch,
    output logic                illegal_o,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic                ex_jal,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic                wb_jal
);

    ctrl_bundle_t     dec_ctrl;
    logic             dec_jump;
    logic             dec_branch;
    logic             dec_uses_rt;
    logic             dec_undecodable;

    ctrl_bundle_t     ex_bundle_reg;
    logic [REG_W-1:0] ex_dest_reg;
    mem_ctrl_t        mem_bundle_reg;
    wb_ctrl_t         wb_bundle_reg;

    logic             load_use;
    logic             mul_stall;
    logic             inject_bubble;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_decode (
        .opcode      (id_opcode),
        .funct       (id_funct),
        .ctrl        (dec_ctrl),
        .jump        (dec_jump),
        .branch      (dec_branch),
        .uses_rt     (dec_uses_rt),
        .undecodable (dec_undecodable)
    );

    assign illegal_o = id_valid & dec_undecodable;
    assign id_jump   = id_valid & dec_jump & ~flush_i;
    assign id_branch = id_valid & dec_branch & ~flush_i;

    // ex_dest_reg is only ever non-zero-meaningful for loads, whose destination is rt.
    assign load_use = id_valid & ex_bundle_reg.mem_read & (ex_dest_reg != '0) &
                      ((ex_dest_reg == id_rs) | ((ex_dest_reg == id_rt) & dec_uses_rt));

    // Flush beats any hazard: the squashed instruction need not wait.
    assign stall_o       = ~rst & ~flush_i & (load_use | mul_stall);
    assign inject_bubble = ~id_valid | flush_i | stall_o | illegal_o;

`ifdef CTRL_MUL_INTERLOCK_EN
    localparam int MUL_CNT_W = $clog2(MUL_LAT + 1);

    logic [MUL_CNT_W-1:0] mul_cnt_reg;
    logic [MUL_CNT_W-1:0] mul_cnt_next;
    logic                 id_is_multu;
    logic                 id_is_mfhilo;
    logic                 mul_busy;

    assign id_is_multu  = id_valid & (id_opcode == OPCODE_W'(R_FORMAT)) &
                          (id_funct == FUNCT_W'(MULTU));
    assign id_is_mfhilo = id_valid & (id_opcode == OPCODE_W'(R_FORMAT)) &
                          ((id_funct == FUNCT_W'(MFHI)) | (id_funct == FUNCT_W'(MFLO)));
    assign mul_busy     = (mul_cnt_reg != '0);
    assign mul_stall    = mul_busy & (id_is_mfhilo | id_is_multu);

    always_comb begin
        mul_cnt_next = mul_cnt_reg;
        if (id_is_multu & ~inject_bubble) begin
            mul_cnt_next = MUL_CNT_W'(MUL_LAT);
        end else if (mul_busy) begin
            mul_cnt_next = mul_cnt_reg - MUL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt_reg <= '0;
        end else begin
            mul_cnt_reg <= mul_cnt_next;
        end
    end
`else
    logic [31:0] unused_mul_lat;

    assign unused_mul_lat = MUL_LAT;
    assign mul_stall      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bundle_reg  <= '0;
            ex_dest_reg    <= '0;
            mem_bundle_reg <= '0;
            wb_bundle_reg  <= '0;
        end else begin
            if (inject_bubble) begin
                ex_bundle_reg <= '0;
                ex_dest_reg   <= '0;
            end else begin
                ex_bundle_reg <= dec_ctrl;
                ex_dest_reg   <= dec_ctrl.jal ? REG_W'(LINK_REG) : id_rt;
            end
            mem_bundle_reg.mem_read   <= ex_bundle_reg.mem_read;
            mem_bundle_reg.mem_write  <= ex_bundle_reg.mem_write;
            mem_bundle_reg.reg_write  <= ex_bundle_reg.reg_write;
            mem_bundle_reg.mem_to_reg <= ex_bundle_reg.mem_to_reg;
            mem_bundle_reg.jal        <= ex_bundle_reg.jal;
            wb_bundle_reg.reg_write   <= mem_bundle_reg.reg_write;
            wb_bundle_reg.mem_to_reg  <= mem_bundle_reg.mem_to_reg;
            wb_bundle_reg.jal         <= mem_bundle_reg.jal;
        end
    end

    assign ex_reg_dst    = ex_bundle_reg.reg_dst;
    assign ex_alu_src    = ex_bundle_reg.alu_src;
    assign ex_jal        = ex_bundle_reg.jal;
    assign ex_alu_op     = ALUOP_W'(ex_bundle_reg.alu_op);
    assign ex_mem_read   = ex_bundle_reg.mem_read;
    assign ex_mem_write  = ex_bundle_reg.mem_write;
    assign mem_mem_read  = mem_bundle_reg.mem_read;
    assign mem_mem_write = mem_bundle_reg.mem_write;
    assign wb_reg_write  = wb_bundle_reg.reg_write;
    assign wb_mem_to_reg = wb_bundle_reg.mem_to_reg;
    assign wb_jal        = wb_bundle_reg.jal;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed self-checking bench for control_pipeline; expectations for the multu
// interlock follow CTRL_MUL_INTERLOCK_EN with MUL_LAT=4.
module tb_control_pipeline;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BAD   = 6'h3f;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_MFLO  = 6'h12;

`ifdef CTRL_MUL_INTERLOCK_EN
    localparam logic MUL_STALL_EXP = 1'b1;
`else
    localparam logic MUL_STALL_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush_i;
    logic       stall_o;
    logic       id_jump;
    logic       id_branch;
    logic       illegal_o;
    logic       ex_reg_dst;
    logic       ex_alu_src;
    logic       ex_jal;
    logic [1:0] ex_alu_op;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       mem_mem_read;
    logic       mem_mem_write;
    logic       wb_reg_write;
    logic       wb_mem_to_reg;
    logic       wb_jal;

    int checks = 0;
    int errors = 0;

    control_pipeline #(
        .OPCODE_W (6),
        .FUNCT_W  (6),
        .REG_W    (5),
        .ALUOP_W  (2),
        .LINK_REG (31),
        .MUL_LAT  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .id_jump       (id_jump),
        .id_branch     (id_branch),
        .illegal_o     (illegal_o),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_jal        (ex_jal),
        .ex_alu_op     (ex_alu_op),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_jal        (wb_jal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic fl);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
        flush_i   = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_R, 6'h00, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        // Reset held with a load sitting in ID
        rst = 1'b1;
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        cycle();
        cycle();
        check("rst_stall", stall_o, 0);
        check("rst_ex_mem_read", ex_mem_read, 0);
        check("rst_mem_mem_read", mem_mem_read, 0);
        check("rst_wb_mem_to_reg", wb_mem_to_reg, 0);
        check("rst_wb_reg_write", wb_reg_write, 0);

        rst = 1'b0;
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd9, 1'b0);
        check("lw_no_stall", stall_o, 0);
        cycle();
        check("lw_ex_mem_read", ex_mem_read, 1);
        check("lw_ex_alu_src", ex_alu_src, 1);
        check("lw_ex_alu_op", ex_alu_op, 0);
        idle();
        cycle();
        check("lw_mem_mem_read", mem_mem_read, 1);
        cycle();
        check("lw_wb_mem_to_reg", wb_mem_to_reg, 1);
        check("lw_wb_reg_write", wb_reg_write, 1);

        // Load-use on rs
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        cycle();
        drive(1'b1, OP_R, FN_ADD, 5'd8, 5'd2, 1'b0);
        check("lu_stall", stall_o, 1);
        cycle();
        check("lu_stall_once", stall_o, 0);
        check("lu_bubble_reg_dst", ex_reg_dst, 0);
        check("lu_bubble_alu_op", ex_alu_op, 0);
        check("lu_bubble_mem_read", ex_mem_read, 0);
        cycle();
        check("lu_add_reg_dst", ex_reg_dst, 1);
        check("lu_add_alu_op", ex_alu_op, 2);
        idle();

        // $zero destination never stalls
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd0, 1'b0);
        cycle();
        drive(1'b1, OP_R, FN_ADD, 5'd0, 5'd0, 1'b0);
        check("zero_no_stall", stall_o, 0);
        cycle();
        check("zero_add_in_ex", ex_reg_dst, 1);

        // ADDIU rt is a destination, not a source
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        cycle();
        drive(1'b1, OP_ADDIU, 6'h00, 5'd3, 5'd8, 1'b0);
        check("addiu_no_stall", stall_o, 0);
        cycle();
        check("addiu_ex_alu_src", ex_alu_src, 1);

        // SW reads rt, so it stalls
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        cycle();
        drive(1'b1, OP_SW, 6'h00, 5'd3, 5'd8, 1'b0);
        check("sw_stall", stall_o, 1);
        cycle();
        check("sw_bubble_mem_write", ex_mem_write, 0);
        cycle();
        check("sw_ex_mem_write", ex_mem_write, 1);
        idle();

        // Flush beats the load-use hazard
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        cycle();
        drive(1'b1, OP_R, FN_ADD, 5'd8, 5'd2, 1'b1);
        check("flush_no_stall", stall_o, 0);
        cycle();
        idle();
        check("flush_bubble_reg_dst", ex_reg_dst, 0);
        cycle();
        check("flush_lw_in_wb", wb_reg_write, 1);
        cycle();
        check("flush_add_not_in_wb", wb_reg_write, 0);

        // Jump/branch decode
        drive(1'b1, OP_J, 6'h00, 5'd0, 5'd0, 1'b0);
        check("j_jump", id_jump, 1);
        check("j_branch", id_branch, 0);
        check("j_illegal", illegal_o, 0);
        drive(1'b1, OP_J, 6'h00, 5'd0, 5'd0, 1'b1);
        check("j_flushed", id_jump, 0);
        drive(1'b1, OP_BEQ, 6'h00, 5'd1, 5'd2, 1'b0);
        check("beq_branch", id_branch, 1);
        check("beq_jump", id_jump, 0);
        drive(1'b1, OP_JAL, 6'h00, 5'd0, 5'd0, 1'b0);
        cycle();
        idle();
        check("jal_ex_jal", ex_jal, 1);
        cycle();
        cycle();
        check("jal_wb_reg_write", wb_reg_write, 1);
        check("jal_wb_jal", wb_jal, 1);

        // Undecodable opcode
        drive(1'b0, OP_BAD, 6'h00, 5'd0, 5'd0, 1'b0);
        check("bad_invalid_not_illegal", illegal_o, 0);
        drive(1'b1, OP_BAD, 6'h00, 5'd0, 5'd0, 1'b0);
        check("bad_illegal", illegal_o, 1);
        cycle();
        idle();
        cycle();
        cycle();
        check("bad_wb_reg_write", wb_reg_write, 0);

        // Reset mid-stream
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd9, 1'b0);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_ex_mem_read", ex_mem_read, 0);
        check("midrst_mem_mem_read", mem_mem_read, 0);

        // multu never writes the register file
        drive(1'b1, OP_R, FN_MULTU, 5'd4, 5'd5, 1'b0);
        cycle();
        idle();
        cycle();
        cycle();
        check("multu_wb_reg_write", wb_reg_write, 0);
        cycle();
        cycle();

        // multu then mflo: 4 stall cycles with the interlock, none without
        drive(1'b1, OP_R, FN_MULTU, 5'd4, 5'd5, 1'b0);
        check("multu_idle_no_stall", stall_o, 0);
        cycle();
        drive(1'b1, OP_R, FN_MFLO, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mflo_stall_%0d", i), stall_o, MUL_STALL_EXP);
            cycle();
        end
        check("mflo_released", stall_o, 0);
        cycle();
        check("mflo_in_ex", ex_reg_dst, 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
Parametrised pipelined control unit for the 5-stage MIPS core. Decodes opcode/funct in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. Owns load-use hazard detection, stall bubbles and branch/jump flush. Datapath pipeline registers consume ex_*, mem_* and wb_* directly.

Parameters:
OPCODE_W, 6, opcode field width
FUNCT_W, 6, funct field width
REG_W, 5, register-address width
ALUOP_W, 2, ALUOp width to ALU control
LINK_REG, 31, destination register written by JAL
MUL_LAT, 4, multu occupancy in cycles (used only with CTRL_MUL_INTERLOCK_EN)

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous to clk, active-high
id_valid  in  1  ID holds a real instruction
id_opcode  in  OPCODE_W  instruction[31:26]
id_funct  in  FUNCT_W  instruction[5:0]
id_rs  in  REG_W  instruction[25:21]
id_rt  in  REG_W  instruction[20:16]
flush_i  in  1  branch/jump taken; squash the instruction in ID
stall_o  out  1  hold PC and IF/ID this cycle
id_jump  out  1  combinational: ID is J/JAL and not flushed
id_branch  out  1  combinational: ID is BEQ and not flushed
illegal_o  out  1  combinational: ID opcode/funct undecodable and id_valid
ex_reg_dst, ex_alu_src, ex_jal  out  1 each  EX-stage controls
ex_alu_op  out  ALUOP_W  EX-stage ALUOp
ex_mem_read, ex_mem_write  out  1 each  carried to MEM
mem_mem_read, mem_mem_write  out  1 each  MEM-stage controls
wb_reg_write, wb_mem_to_reg, wb_jal  out  1 each  WB-stage controls

Behaviour:
- Decode (combinational): R-format: RegDst=1, ALUOp=10, RegWrite=1, except funct 011001 (multu): RegWrite=0.
- LW: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00. SW: ALUSrc=1, MemWrite=1, ALUOp=00.
- BEQ: Branch=1, ALUOp=01. ADDIU (9): ALUSrc=1, RegWrite=1, ALUOp=00.
- J (2): Jump=1, Branch=0. JAL (3): Jump=1, RegWrite=1, JAL=1; write-back destination is LINK_REG.
- Any other opcode: all controls 0, illegal_o=1. No X is ever driven.
- Bubble = all-zero bundle. Injected into ID/EX when id_valid=0, flush_i=1, stall_o=1 or illegal_o=1.
- Load-use stall: stall_o=1 when all of the following hold:
  - ex_mem_read=1;
  - EX dest rt != 0;
  - EX dest rt == id_rs, or EX dest rt == id_rt and ID is R-format/BEQ/SW.
- Stall duration and timing: one cycle per hazard. The instruction stays in ID and re-evaluates on the next cycle.
- flush_i and hazard in the same cycle: flush wins, stall_o=0, bubble enters EX.
- EX→MEM→WB always advance every cycle; no back-pressure downstream.
- Latency: ID decode appears on ex_* at +1 cycle, mem_* at +2, wb_* at +3.
- Reset: every registered output is 0 (ex_*, mem_*, wb_*, stored EX rt, mul counter); stall_o=0.
- rst mid-stream clears all in-flight bundles on the same edge. rst has priority over stall and flush.

Optional Feature:
CTRL_MUL_INTERLOCK_EN
- Defined:
  - A multu leaving ID loads a busy counter with MUL_LAT; it decrements each cycle to 0.
  - mfhi (funct 010000) or mflo (010010) in ID while counter != 0 forces stall_o=1.
  - A second multu while busy also stalls.
  - flush_i suppresses the stall for that cycle.
  - Counter saturates at 0; reset clears it.
- Undefined: no counter; mfhi/mflo decode as plain R-format with no interlock.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants: R_FORMAT, LW, SW, BEQ, ADDIU, J, JAL;
  - funct constants: MULTU, MFHI, MFLO;
  - ALUOp encodings;
  - a packed ctrl_bundle_t typedef: reg_dst, alu_src, alu_op, mem_read, mem_write, reg_write, mem_to_reg, jal.
- Sub-module: ctrl_decode (pure combinational opcode/funct→ctrl_bundle_t + illegal flag).
- Top holds the stage registers, hazard logic and the optional counter.

Test Plan:
- Reset: rst=1 for 2 cycles with LW in ID → all ex_/mem_/wb_ outputs 0, stall_o=0; after release, LW bundle reaches wb_mem_to_reg=1 three cycles later.
- Load-use: LW $t0 (rt=8) then ADD rs=8 → stall_o=1 for exactly 1 cycle, ex_* all 0 that cycle, ADD bundle in EX next cycle.
- No false stall: LW rt=0 followed by ADD rs=0 → stall_o stays 0. SW with rt=8 after LW rt=8 → stall_o=1.
- Flush vs stall: load-use hazard with flush_i=1 same cycle → stall_o=0, bubble in EX, ID instruction never reaches WB.
- Decode coverage: J → id_jump=1, id_branch=0; JAL → wb_reg_write=1, wb_jal=1 at +3; opcode 6'd63 → illegal_o=1 and wb_reg_write=0 at +3.
- With CTRL_MUL_INTERLOCK_EN, MUL_LAT=4: multu then mflo → stall_o=1 for 4 cycles, then mflo proceeds. Without the macro: no stall.
